// File: rtl/q1_rx.sv
// Serial nibble receiver: start bit, four coded data bits (LSB first), even parity, stop bit.
// Optionally Gray-decodes the nibble; pulses valid on a good frame or err on a bad one.
module q1_rx (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  input  logic s,
  output logic b0,
  output logic b1,
  output logic b2,
  output logic b3,
  output logic valid,
  output logic err,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  shift_q, shift_d;
  logic        mode_q, mode_d;
  logic        par_q, par_d;
  logic [3:0]  nib_q, nib_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        frame_good;

  // Gray decode runs MSB-down, each bit folding in the one above it.
  function automatic logic [3:0] decode(input logic [3:0] g, input logic gray);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return gray ? b : g;
  endfunction

  assign frame_good = sin && ((^shift_q ^ par_q) == 1'b0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    par_d   = par_q;
    nib_d   = nib_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sin) begin
          state_d = DATA;
          cnt_d   = 2'd0;
          mode_d  = s;
        end
      end
      DATA: begin
        shift_d[cnt_q] = sin;
        if (cnt_q == 2'd3) begin
          state_d = PARITY;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      PARITY: begin
        par_d   = sin;
        state_d = STOP;
      end
      STOP: begin
        // Sampling the stop bit always ends the frame, good or bad.
        state_d = IDLE;
        if (frame_good) begin
          nib_d   = decode(shift_q, mode_q);
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      shift_q <= 4'd0;
      mode_q  <= 1'b0;
      par_q   <= 1'b0;
      nib_q   <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      nib_q   <= nib_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign {b3, b2, b1, b0} = nib_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_q1_rx.sv
// Directed self-checking bench for q1_rx: inputs change on falling edges,
// outputs are observed on falling edges, half a cycle after the rising edge that produced them.
module tb_q1_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b1;
  logic s   = 1'b0;
  logic b0, b1, b2, b3, valid, err, busy;

  int checks = 0;
  int passed = 0;
  int cycleCnt = 0;
  int pulseCnt = 0;
  int validCnt = 0;
  int lastValidCycle = 0;
  int prevValidCycle = 0;
  bit bothSeen = 1'b0;

  logic [5:0] obs;
  assign obs = {valid, err, b3, b2, b1, b0};

  q1_rx dut (
    .clk(clk), .rst(rst), .sin(sin), .s(s),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .valid(valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: timestamps valid pulses and flags any overlap of valid and err.
  always @(negedge clk) begin
    cycleCnt++;
    if (valid || err) pulseCnt++;
    if (valid) begin
      validCnt++;
      prevValidCycle = lastValidCycle;
      lastValidCycle = cycleCnt;
    end
    if (valid && err) bothSeen = 1'b1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives a full 7-bit frame; caller must be at a falling edge. Returns right after driving stop.
  task automatic send_frame(input logic mode, input logic [3:0] g, input logic p,
                            input logic stopBit, input logic flipS);
    sin = 1'b0;
    s   = mode;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flipS) s = ~mode;
      sin = g[i];
    end
    @(negedge clk);
    sin = p;
    @(negedge clk);
    sin = stopBit;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sin = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 6'b000000) $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 6'b000000);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else passed++;
    sin = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_gray();
    send_frame(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    sin = 1'b1;
    checks++;
    if (obs !== 6'b100100) $display("[TB] FAIL gray_0110: got %b expected %b", obs, 6'b100100);
    else passed++;
    @(negedge clk);
    checks++;
    if (obs !== 6'b000100) $display("[TB] FAIL gray_pulse_width: got %b expected %b", obs, 6'b000100);
    else passed++;
  endtask

  task automatic test_passthrough();
    send_frame(1'b0, 4'b0110, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    sin = 1'b1;
    checks++;
    if (obs !== 6'b100110) $display("[TB] FAIL pass_0110: got %b expected %b", obs, 6'b100110);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_parity_error();
    send_frame(1'b1, 4'b0110, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    sin = 1'b1;
    checks++;
    if (obs !== 6'b010110) $display("[TB] FAIL parity_err: got %b expected %b", obs, 6'b010110);
    else passed++;
    @(negedge clk);
    checks++;
    if (obs !== 6'b000110) $display("[TB] FAIL parity_err_width: got %b expected %b", obs, 6'b000110);
    else passed++;
  endtask

  task automatic test_stop_error();
    send_frame(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== 6'b010110) $display("[TB] FAIL stop_err: got %b expected %b", obs, 6'b010110);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL stop_err_idle: got busy=%b expected 0", busy);
    else passed++;
    send_frame(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    sin = 1'b1;
    checks++;
    if (obs !== 6'b101010) $display("[TB] FAIL after_stop_err: got %b expected %b", obs, 6'b101010);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_mode_hold();
    send_frame(1'b1, 4'b0110, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    sin = 1'b1;
    s   = 1'b0;
    checks++;
    if (obs !== 6'b100100) $display("[TB] FAIL mode_latched: got %b expected %b", obs, 6'b100100);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_busy();
    logic [3:0] g;
    g = 4'b1111;
    s   = 1'b0;
    sin = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL busy_before_start: got %b expected 0", busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL busy_after_start: got %b expected 1", busy);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      sin = g[i];
      @(negedge clk);
    end
    sin = 1'b0;
    @(negedge clk);
    sin = 1'b1;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL busy_in_stop: got %b expected 1", busy);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL busy_after_stop: got %b expected 0", busy);
    else passed++;
    checks++;
    if (obs !== 6'b101111) $display("[TB] FAIL busy_frame_data: got %b expected %b", obs, 6'b101111);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int pulsesBefore;
    pulsesBefore = pulseCnt;
    sin = 1'b0;
    s   = 1'b1;
    @(negedge clk);
    sin = 1'b1;
    @(negedge clk);
    sin = 1'b0;
    @(negedge clk);
    sin = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs !== 6'b000000) $display("[TB] FAIL midframe_reset_out: got %b expected %b", obs, 6'b000000);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL midframe_reset_busy: got %b expected 0", busy);
    else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if (pulseCnt !== pulsesBefore) $display("[TB] FAIL midframe_no_pulse: got %0d pulses expected %0d", pulseCnt, pulsesBefore);
    else passed++;
    send_frame(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    sin = 1'b1;
    checks++;
    if (obs !== 6'b100100) $display("[TB] FAIL after_reset_frame: got %b expected %b", obs, 6'b100100);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int validsBefore;
    validsBefore = validCnt;
    send_frame(1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs !== 6'b100001) $display("[TB] FAIL b2b_first: got %b expected %b", obs, 6'b100001);
    else passed++;
    send_frame(1'b1, 4'b1000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    sin = 1'b1;
    checks++;
    if (obs !== 6'b101111) $display("[TB] FAIL b2b_second: got %b expected %b", obs, 6'b101111);
    else passed++;
    @(negedge clk);
    checks++;
    if (validCnt - validsBefore !== 2) $display("[TB] FAIL b2b_pulse_count: got %0d expected 2", validCnt - validsBefore);
    else passed++;
    checks++;
    if (lastValidCycle - prevValidCycle !== 7) $display("[TB] FAIL b2b_spacing: got %0d expected 7", lastValidCycle - prevValidCycle);
    else passed++;
  endtask

  task automatic test_exclusive();
    checks++;
    if (bothSeen !== 1'b0) $display("[TB] FAIL valid_err_overlap: got %b expected 0", bothSeen);
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_gray();
    test_passthrough();
    test_parity_error();
    test_stop_error();
    test_mode_hold();
    test_busy();
    test_reset_midframe();
    test_back_to_back();
    test_exclusive();
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/q1_rx.md
Q1_RX -- requirements
Module: q1_rx

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have: sin  input  1  serial line; idle high; one bit per clk cycle.
REQ-004 SHALL have: s  input  1  decode mode; 1 = Gray-to-binary, 0 = pass-through; sampled only at start bit.
REQ-005 SHALL have: b0, b1, b2, b3  output  1 each  decoded nibble, registered; b0 = LSB.
REQ-006 SHALL have: valid  output  1  one-cycle pulse when b0..b3 update with a good frame.
REQ-007 SHALL have: err  output  1  one-cycle pulse on parity or stop-bit failure.
REQ-008 SHALL have: busy  output  1  high while a frame is in progress (any state except IDLE).

Function
REQ-009 Frame format SHALL be: start (0), then g0, g1, g2, g3 (coded nibble, LSB first), then even parity bit P, then stop (1). Total 7 bit-cycles.
REQ-010 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-011 IDLE: sin=0 sampled SHALL move the FSM to DATA, clear the bit counter, and latch s into a mode register. sin=1 SHALL keep the FSM in IDLE.
REQ-012 DATA SHALL shift sin into bit position cnt (0..3) each cycle. After cnt=3 is sampled, the FSM SHALL move to PARITY. cnt is 2 bits and SHALL never wrap within a frame.
REQ-013 PARITY SHALL sample P and move to STOP. Parity is good when g0^g1^g2^g3^P = 0.
REQ-014 STOP SHALL sample sin and always return to IDLE on the same edge.
REQ-015 Good frame = stop bit 1 AND parity good. On a good frame, b0..b3 SHALL load the decoded nibble and valid SHALL be 1 for exactly the next cycle.
REQ-016 Bad frame: err SHALL be 1 for exactly the next cycle; b0..b3 SHALL hold; valid SHALL stay 0. valid and err SHALL never both be 1.
REQ-017 Decode with latched mode = 1 SHALL be: b3=g3; b2=b3^g2; b1=b2^g1; b0=b1^g0.
REQ-018 Decode with latched mode = 0 SHALL be: bi=gi for i=0..3.
REQ-019 Changes on s after the start bit SHALL NOT affect the frame in progress.
REQ-020 Latency: if the start bit is sampled at edge T0, data bits SHALL be sampled at T1..T4, parity at T5, stop at T6; outputs and the valid/err pulse SHALL be visible after T6 until T7.
REQ-021 Back-to-back frames: the FSM is IDLE after T6, so sin=0 at T7 SHALL be taken as the next start bit with no dead cycle.
REQ-022 After a stop-bit error, the FSM SHALL return to IDLE. The next sampled 0 SHALL start a new frame; there is no resync delay.
REQ-023 busy SHALL be 1 from the cycle after the start bit is sampled through the STOP state, and 0 in IDLE.

Reset
REQ-024 rst=1 at a clock edge SHALL force: state=IDLE, cnt=0, shift register=0, mode register=0, b0..b3=0, valid=0, err=0, busy=0.
REQ-025 rst SHALL override everything, including mid-frame. A partial frame SHALL be discarded with no valid or err pulse.
REQ-026 After rst is released, the first sampled sin=0 SHALL start a frame.

Verification
REQ-027 s=1, sin = 1,0,0,1,1,0,0,1 (idle, start, g0..g3=0110, P=0, stop) -> valid pulse; {b3,b2,b1,b0} = 0100; err=0.
REQ-028 Same frame with s=0 -> valid pulse; {b3,b2,b1,b0} = 0110.
REQ-029 Same frame with P=1 -> err pulse; valid=0; b0..b3 unchanged from the prior value.
REQ-030 Stop bit=0 -> err pulse; FSM returns to IDLE; an immediate following good frame (g=1111, P=0, s=1) -> {b3..b0} = 1010.
REQ-031 rst=1 asserted during g2 sampling -> all outputs 0 next cycle, busy=0, no pulse; a subsequent good frame decodes correctly.
REQ-032 Two good frames back-to-back (start at T7): g=0001 P=1, then g=1000 P=1, s=1 -> {b3..b0} = 0001 then 1111; valid pulses exactly 7 cycles apart.
